// File: rtl/alu_iter.sv
// alu_iter: multi-cycle RISC-V ALU with an iterative 1-bit/cycle shifter and start/done handshake.
// Define ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done
);
    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]    shamt;
    logic             slt;
    logic [WIDTH-1:0] alu_res;

    assign shamt = SrcB[SW-1:0];
    assign slt   = $signed(SrcA) < $signed(SrcB);

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            4'b0000: alu_res = SrcA + SrcB;
            4'b0001: alu_res = SrcA - SrcB;
            4'b0010: alu_res = SrcA & SrcB;
            4'b0011: alu_res = SrcA | SrcB;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, slt};
`ifdef ALU_BARREL_SHIFT_EN
            4'b0110: alu_res = SrcA << shamt;
            4'b1000: alu_res = SrcA >> shamt;
            4'b1110: alu_res = WIDTH'($signed(SrcA) >>> shamt);
`else
            // only shift-by-0 completes here; nonzero amounts run through SHIFT
            4'b0110, 4'b1000, 4'b1110: alu_res = SrcA;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= start;
            if (start) begin
                res_q  <= alu_res;
                zero_q <= (alu_res == '0);
            end
        end
    end

    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign done      = done_q;
    assign busy      = 1'b0;
`else
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_sh, res_q, res_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             zero_q, done_q, done_d;
    logic             is_shift, launch, last;

    assign is_shift = ALUControl inside {4'b0110, 4'b1000, 4'b1110};
    assign launch   = start && is_shift && |shamt;
    assign last     = cnt_q == SW'(1);
    // op_q = {shift left, arithmetic fill}
    assign acc_sh   = op_q[1] ? {acc_q[WIDTH-2:0], 1'b0}
                              : {op_q[0] & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= (res_d == '0);
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (launch ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        res_d  = res_q;
        done_d = 1'b0;
        if (state_q == IDLE && start) begin
            if (launch) begin
                acc_d = SrcA;
                cnt_d = shamt;
                op_d  = {ALUControl == 4'b0110, ALUControl == 4'b1110};
            end else begin
                res_d  = alu_res;
                done_d = 1'b1;
            end
        end else if (state_q == SHIFT) begin
            acc_d = acc_sh;
            cnt_d = cnt_q - SW'(1);
            if (last) begin
                res_d  = acc_sh;
                done_d = 1'b1;
            end
        end
    end

    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign done      = done_q;
    assign busy      = (state_q == SHIFT);
`endif
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter (WIDTH=32).
// Shift latency/busy expectations follow ALU_BARREL_SHIFT_EN when it is defined.
module tb_alu_iter;
`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, zero, busy, done;
    logic [3:0]  ctl;
    logic [31:0] a, b, res;
    int          passes = 0;
    int          total = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ctl),
        .SrcA(a), .SrcB(b), .ALUResult(res), .Zero(zero), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        ctl = c; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // bounded wait for done; lat counts edges since acceptance, bc counts busy cycles seen
    task automatic wait_done(output int lat, output int bc);
        lat = 1; bc = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] c, input logic [31:0] x,
                       input logic [31:0] y, input int n, input logic [31:0] exp);
        int lat, bc;
        issue(c, x, y);
        wait_done(lat, bc);
        check({tag, "_lat"}, 32'(lat), BARREL ? 32'd1 : 32'(n + 1));
        check({tag, "_busycyc"}, 32'(bc), BARREL ? 32'd0 : 32'(n));
        check({tag, "_res"}, res, exp);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'b0});
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int lat, bc, ndone;
        reset = 1'b1; start = 1'b0; ctl = 4'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", res, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_done", {31'b0, done}, 32'd0);

        issue(4'b0000, 32'hFFFF_FFFF, 32'h1);
        check("add_done", {31'b0, done}, 32'd1);
        check("add_res", res, 32'h0);
        check("add_zero", {31'b0, zero}, 32'd1);
        @(posedge clk); #1;
        check("add_done_pulse", {31'b0, done}, 32'd0);
        check("add_res_hold", res, 32'h0);

        run("sub", 4'b0001, 32'd5, 32'd7, 0, 32'hFFFF_FFFE);
        run("slt", 4'b0101, 32'hFFFF_FFFF, 32'd1, 0, 32'h1);
        run("slt_neg", 4'b0101, 32'd1, 32'hFFFF_FFFF, 0, 32'h0);
        run("and", 4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_F000);
        run("or", 4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_FFF0);
        run("illegal", 4'b0100, 32'h1234_5678, 32'h1, 0, 32'h0);
        run("sll0", 4'b0110, 32'h1234_5678, 32'h20, 0, 32'h1234_5678);
        run("sra4", 4'b1110, 32'h8000_0000, 32'd4, 4, 32'hF800_0000);
        run("srl4", 4'b1000, 32'h8000_0000, 32'd4, 4, 32'h0800_0000);
        run("sll31", 4'b0110, 32'h1, 32'd31, 31, 32'h8000_0000);
        run("sra31", 4'b1110, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF);

        if (!BARREL) begin
            issue(4'b0110, 32'h1, 32'd3);
            ctl = 4'b0000; a = 32'd5; b = 32'd6; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1F;
            check("ign_busy", {31'b0, busy}, 32'd1);
            wait_done(lat, bc);
            check("ign_lat", 32'(lat), 32'd3);
            check("ign_res", res, 32'h8);
            issue(4'b0000, 32'd2, 32'd3);
            check("b2b_done", {31'b0, done}, 32'd1);
            check("b2b_res", res, 32'd5);

            issue(4'b1000, 32'hFFFF_FFFF, 32'd10);
            repeat (2) begin @(posedge clk); #1; end
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check("abort_busy", {31'b0, busy}, 32'd0);
            check("abort_res", res, 32'h0);
            check("abort_zero", {31'b0, zero}, 32'd1);
            ndone = 0;
            for (int i = 0; i < 15; i++) begin
                if (done === 1'b1) ndone++;
                @(posedge clk); #1;
            end
            check("abort_no_done", 32'(ndone), 32'd0);
            run("post_abort", 4'b0000, 32'd1, 32'd1, 0, 32'd2);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Multi-cycle integer ALU for the RISC-V datapath, sitting directly downstream of the ALU decoder and consuming its 4-bit `ALUControl` code. Logic, add/sub and compare operations complete in one cycle; shifts run on an iterative one-bit-per-cycle shifter to save area, with a start/done handshake toward the controller. Operands are captured at acceptance, and the result is held registered until the next accepted operation.

## Interface
- `WIDTH`, default 32: operand and result width; shift amount is `SrcB[$clog2(WIDTH)-1:0]`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted when high at a rising edge with `busy`=0.
- `ALUControl`  in  4  operation code from the ALU decoder.
- `SrcA`  in  WIDTH  operand A.
- `SrcB`  in  WIDTH  operand B / shift amount.
- `ALUResult`  out  WIDTH  registered result, held until the next completion.
- `Zero`  out  1  registered, equals (`ALUResult`==0).
- `busy`  out  1  high while an iterative shift is in progress.
- `done`  out  1  one-cycle pulse; `ALUResult`/`Zero` are valid in this cycle.

## Operation
- Codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 slt (signed, result 1/0), 0110 sll, 1000 srl, 1110 sra (fills with `SrcA` MSB). Any other code gives result 0, completes as a single-cycle op.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, SHIFT.
  - IDLE, accepted non-shift op, or shift with amount 0: register result (shift-by-0 gives `SrcA`), pulse `done`, stay IDLE.
  - IDLE, accepted shift with amount n≥1: load accumulator=`SrcA`, counter=n, capture op, go to SHIFT.
  - SHIFT: each edge shifts the accumulator one bit in the captured direction/fill, counter decrements; on the edge where counter goes 1→0, write result, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored (not queued). Input changes during SHIFT have no effect.
- `busy`=1 exactly when state is SHIFT; `busy` and `done` are never high together.
- A `start` in the same cycle that `done` is high is accepted (state is already IDLE).
- `ALUResult` and `Zero` change only at completion or reset.

## Timing
- Reset values: `ALUResult`=0, `Zero`=1, `busy`=0, `done`=0, state IDLE, counter 0.
- `start` accepted at edge k, non-shift or shift-by-0: `done` high in the cycle after edge k (latency 1).
- Shift by n≥1 accepted at edge k: `busy` high after edges k..k+n-1, `done` high after edge k+n (latency n+1); max n = WIDTH-1.
- Reset asserted mid-shift: at that edge, abort to IDLE, all outputs take reset values; no `done` for the aborted op.
- Reset has priority over `start` at the same edge.

## Configuration
- `ALU_BARREL_SHIFT_EN`: when defined, shifts use a combinational barrel shifter and complete like non-shift ops (latency 1); SHIFT state and counter are removed, and `busy` is tied to 0. When undefined, the iterative shifter described above is used.

## Test plan
- Reset, then idle: `ALUResult`=0, `Zero`=1, `busy`=0, `done`=0.
- add 0xFFFFFFFF+1 -> `done` at latency 1, result 0, `Zero`=1; sub 5-7 -> 0xFFFFFFFE; slt -1 vs 1 -> 1.
- sra 0x80000000 by 4 -> `busy` for 4 cycles, `done` at latency 5, result 0xF8000000; srl same -> 0x08000000; sll 1 by 31 -> 0x80000000 at latency 32.
- During sll 0x1 by 3, pulse `start` with add and change operands -> ignored, result 0x8; `start` issued in the `done` cycle -> accepted back-to-back.
- Reset asserted 2 cycles into shift by 10 -> next cycle `busy`=0, `ALUResult`=0, `Zero`=1, no `done` pulse.
- With `ALU_BARREL_SHIFT_EN`: sra 0x80000000 by 31 -> 0xFFFFFFFF at latency 1, `busy` never high; shift by 0 and illegal code 0100 -> result `SrcA` and 0 respectively.
